// File: rtl/ofs_fim_eth_if_pkg.sv
// ============================================================================
// Module      : ofs_fim_eth_if_pkg
// Description : Shared FIM Ethernet interface constants and types. It supplies
//               the TX packet beat width and the TX error sideband width. It
//               also defines the state type for the packet-level TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofs_fim_eth_if_pkg;

  // Width of one TX AXI-S data beat toward the HSSI subsystem.
  localparam int ETH_PACKET_WIDTH   = 64;
  // Width of the per-beat TX error/sideband field (tuser).
  localparam int ETH_TX_ERROR_WIDTH = 1;

  // Packet-level TX arbiter: IDLE = no owner, BUSY = a port owns the channel.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } eth_tx_arb_state_e;

endpackage : ofs_fim_eth_if_pkg

`default_nettype wire

// File: rtl/axis_register.sv
// ============================================================================
// Module      : axis_register
// Description : One-stage AXI-S register slice.
//               MODE=0 is a skid buffer that fully registers s_tready, so no
//               combinational path runs from m_tready to s_tready.
//               Any other MODE is a simple pipeline register whose s_tready
//               depends combinationally on m_tready.
//               Disabled sideband fields are not carried. On the output,
//               tkeep reads as all ones and the other fields read as zero.
// Ports       : clk, rst_n           - clock, async active-low reset
//               s_t*                 - slave (input) AXI-S channel
//               m_t*                 - master (output) AXI-S channel
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_register #(
  parameter int MODE           = 0,
  parameter int TREADY_RST_VAL = 0,
  parameter int ENABLE_TKEEP   = 1,
  parameter int ENABLE_TLAST   = 1,
  parameter int ENABLE_TID     = 0,
  parameter int ENABLE_TDEST   = 0,
  parameter int ENABLE_TUSER   = 1,
  parameter int TDATA_WIDTH    = 64,
  parameter int TID_WIDTH      = 8,
  parameter int TDEST_WIDTH    = 8,
  parameter int TUSER_WIDTH    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,

  output logic                     s_tready,
  input  logic                     s_tvalid,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TID_WIDTH-1:0]     s_tid,
  input  logic [TDEST_WIDTH-1:0]   s_tdest,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,

  input  logic                     m_tready,
  output logic                     m_tvalid,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TID_WIDTH-1:0]     m_tid,
  output logic [TDEST_WIDTH-1:0]   m_tdest,
  output logic [TUSER_WIDTH-1:0]   m_tuser
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = TDATA_WIDTH + KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  // Payload bit offsets.
  localparam int K_LSB = TDATA_WIDTH;
  localparam int L_BIT = K_LSB + KW;
  localparam int I_LSB = L_BIT + 1;
  localparam int D_LSB = I_LSB + TID_WIDTH;
  localparam int U_LSB = D_LSB + TDEST_WIDTH;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  // Disabled fields are stored as constants so their flops optimise away.
  assign in_payload = {
    (ENABLE_TUSER != 0) ? s_tuser : {TUSER_WIDTH{1'b0}},
    (ENABLE_TDEST != 0) ? s_tdest : {TDEST_WIDTH{1'b0}},
    (ENABLE_TID   != 0) ? s_tid   : {TID_WIDTH{1'b0}},
    (ENABLE_TLAST != 0) ? s_tlast : 1'b0,
    (ENABLE_TKEEP != 0) ? s_tkeep : {KW{1'b1}},
    s_tdata
  };

  assign m_tdata = out_payload[TDATA_WIDTH-1:0];
  assign m_tkeep = out_payload[K_LSB +: KW];
  assign m_tlast = out_payload[L_BIT];
  assign m_tid   = out_payload[I_LSB +: TID_WIDTH];
  assign m_tdest = out_payload[D_LSB +: TDEST_WIDTH];
  assign m_tuser = out_payload[U_LSB +: TUSER_WIDTH];

  generate
    if (MODE == 0) begin : g_skid
      logic          out_valid_q, out_valid_d;
      logic          skid_valid_q, skid_valid_d;
      logic          ready_q, ready_d;
      logic [PW-1:0] out_payload_q, out_payload_d;
      logic [PW-1:0] skid_payload_q, skid_payload_d;
      logic          in_hs;

      assign in_hs = s_tvalid & ready_q;

      always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_payload_d = skid_payload_q;
        if (m_tready || !out_valid_q) begin
          // Output is free: refill from the skid first, else from the input.
          // While the skid is full ready_q is low, so no input beat competes.
          if (skid_valid_q) begin
            out_valid_d   = 1'b1;
            out_payload_d = skid_payload_q;
            skid_valid_d  = 1'b0;
          end else begin
            out_valid_d = in_hs;
            if (in_hs) begin
              out_payload_d = in_payload;
            end
          end
        end else if (in_hs) begin
          // Output stalled: the beat accepted on the registered ready parks here.
          skid_valid_d   = 1'b1;
          skid_payload_d = in_payload;
        end
        ready_d = ~skid_valid_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
          ready_q      <= (TREADY_RST_VAL != 0);
        end else begin
          out_valid_q  <= out_valid_d;
          skid_valid_q <= skid_valid_d;
          ready_q      <= ready_d;
        end
      end

      // The datapath is qualified by the valid flops, so it needs no reset.
      always_ff @(posedge clk) begin
        out_payload_q  <= out_payload_d;
        skid_payload_q <= skid_payload_d;
      end

      assign s_tready    = ready_q;
      assign m_tvalid    = out_valid_q;
      assign out_payload = out_payload_q;
    end else begin : g_pipe
      logic          out_valid_q;
      logic [PW-1:0] out_payload_q;
      logic          ready;

      assign ready = ~out_valid_q | m_tready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
        end else if (ready) begin
          out_valid_q <= s_tvalid;
        end
      end

      always_ff @(posedge clk) begin
        if (ready && s_tvalid) begin
          out_payload_q <= in_payload;
        end
      end

      assign s_tready    = ready;
      assign m_tvalid    = out_valid_q;
      assign out_payload = out_payload_q;
    end
  endgenerate

endmodule : axis_register

`default_nettype wire

// File: rtl/eth_tx_pkt_rr_arb.sv
// ============================================================================
// Module      : eth_tx_pkt_rr_arb
// Description : Packet-level round-robin arbiter that shares one HSSI Ethernet
//               TX AXI-S channel between NUM_PORTS requesters. Ownership
//               changes only at packet boundaries, and the granted stream
//               passes through one registered skid stage.
// Ports       : clk, rst_n     - TX channel clock, async active-low reset
//               port_en        - per-port enable, sampled only at grant decisions
//               s_t*           - NUM_PORTS packed requester AXI-S slaves
//               m_t*           - shared AXI-S master toward the TX pipeline
//               grant_id       - current owner, valid while busy=1
//               busy           - 1 while a port owns the channel
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_pkt_rr_arb
  import ofs_fim_eth_if_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = ETH_PACKET_WIDTH,
  parameter int TUSER_WIDTH = ETH_TX_ERROR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 port_en,

  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  output logic [NUM_PORTS-1:0]                 s_tready,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]     s_tuser,

  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [TDATA_WIDTH-1:0]               m_tdata,
  output logic [TDATA_WIDTH/8-1:0]             m_tkeep,
  output logic                                 m_tlast,
  output logic [TUSER_WIDTH-1:0]               m_tuser,

  output logic [$clog2(NUM_PORTS)-1:0]         grant_id,
  output logic                                 busy
);

  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int KW   = TDATA_WIDTH / 8;

  // Returns {found, index} of the first set bit of elig, scanning
  // ptr+1, ptr+2, ... with wrap. Walking from the far end lets the nearest
  // candidate overwrite the result last.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_PORTS-1:0] elig,
                                            input logic [ID_W-1:0]      ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_PORTS);
      if (elig[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  eth_tx_arb_state_e  state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] others;
  logic [ID_W:0]        pick;
  logic                 is_busy;
  logic                 in_tvalid;
  logic                 in_tready;
  logic [TDATA_WIDTH-1:0] in_tdata;
  logic [KW-1:0]          in_tkeep;
  logic                   in_tlast;
  logic [TUSER_WIDTH-1:0] in_tuser;
  logic                   pkt_end;
  logic                   unused_tid;
  logic                   unused_tdest;

  assign is_busy = (state_q == BUSY);
  assign elig    = s_tvalid & port_en;

  // Granted-port mux into the out stage.
  assign in_tvalid = is_busy & s_tvalid[grant_id_q];
  assign in_tdata  = s_tdata[int'(grant_id_q)*TDATA_WIDTH +: TDATA_WIDTH];
  assign in_tkeep  = s_tkeep[int'(grant_id_q)*KW +: KW];
  assign in_tlast  = s_tlast[grant_id_q];
  assign in_tuser  = s_tuser[int'(grant_id_q)*TUSER_WIDTH +: TUSER_WIDTH];

  // Only the owner sees the out stage's registered ready.
  always_comb begin
    s_tready = '0;
    if (is_busy) begin
      s_tready[grant_id_q] = in_tready;
    end
  end

  assign pkt_end = in_tvalid & in_tready & in_tlast;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    others     = elig;
    others[grant_id_q] = 1'b0;
    pick       = '0;
    case (state_q)
      IDLE: begin
        pick = rr_pick(elig, rr_ptr_q);
        if (pick[ID_W]) begin
          grant_id_d = pick[ID_W-1:0];
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (pkt_end) begin
          rr_ptr_d = grant_id_q;
          // The finishing port may keep the channel only when nobody else wants it.
          pick = rr_pick((others != '0) ? others : elig, grant_id_q);
          if (pick[ID_W]) begin
            grant_id_d = pick[ID_W-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_PORTS - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = is_busy;

  axis_register #(
    .MODE           (0),
    .TREADY_RST_VAL (0),
    .ENABLE_TKEEP   (1),
    .ENABLE_TLAST   (1),
    .ENABLE_TID     (0),
    .ENABLE_TDEST   (0),
    .ENABLE_TUSER   (1),
    .TDATA_WIDTH    (TDATA_WIDTH),
    .TID_WIDTH      (1),
    .TDEST_WIDTH    (1),
    .TUSER_WIDTH    (TUSER_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tready (in_tready),
    .s_tvalid (in_tvalid),
    .s_tdata  (in_tdata),
    .s_tkeep  (in_tkeep),
    .s_tlast  (in_tlast),
    .s_tid    (1'b0),
    .s_tdest  (1'b0),
    .s_tuser  (in_tuser),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (unused_tid),
    .m_tdest  (unused_tdest),
    .m_tuser  (m_tuser)
  );

endmodule : eth_tx_pkt_rr_arb

`default_nettype wire

// File: tb/tb_eth_tx_pkt_rr_arb.sv
// ============================================================================
// Module      : tb_eth_tx_pkt_rr_arb
// Description : Randomised self-checking bench for eth_tx_pkt_rr_arb. A
//               packet-level reference model predicts the channel owner, the
//               per-port ready and the beat stream leaving the two-deep
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_tx_pkt_rr_arb;

  localparam int N  = 4;
  localparam int DW = ofs_fim_eth_if_pkg::ETH_PACKET_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = ofs_fim_eth_if_pkg::ETH_TX_ERROR_WIDTH;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      port_en;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N-1:0]      s_tlast;
  logic [N*UW-1:0]   s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [UW-1:0]     m_tuser;
  logic [1:0]        grant_id;
  logic              busy;

  eth_tx_pkt_rr_arb #(.NUM_PORTS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- requester drivers ----------------
  logic [N-1:0]  v;
  int            len  [N];
  int            bi   [N];
  int            pk   [N];
  logic [DW-1:0] cd   [N];
  logic [KW-1:0] ck   [N];
  logic [UW-1:0] cu   [N];
  logic [N-1:0]  prev_hs;

  // Knobs: valid probability, m_tready probability, max packet length, enable mode.
  int vprob, rprob, maxlen, en_mode;

  // ---------------- reference model ----------------
  // The DUT holds at most two beats (output register plus skid). It accepts
  // a beat whenever fewer than two are held. The owner changes only after
  // the owner's tlast beat is accepted.
  bit     mdl_busy;
  int     mdl_owner;
  int     mdl_last;
  int     mdl_occ;
  beat_t  exp_q[$];
  int     p1_grants;

  function automatic int first_after(input logic [N-1:0] e, input int start);
    for (int k = 1; k <= N; k++) begin
      if (e[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic new_beat(input int i);
    cd[i] = {8'(i), 16'(pk[i]), 8'(bi[i]), 32'($urandom)};
    ck[i] = KW'($urandom);
    cu[i] = UW'($urandom);
  endtask

  task automatic new_pkt(input int i);
    pk[i]++;
    bi[i]  = 0;
    len[i] = 1 + int'($urandom_range(maxlen - 1));
    new_beat(i);
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_owner = 0;
    mdl_last  = N - 1;
    mdl_occ   = 0;
    exp_q.delete();
    prev_hs   = '0;
    v         = '0;
    for (int i = 0; i < N; i++) new_pkt(i);
  endtask

  task automatic apply_inputs();
    s_tvalid = v;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*DW +: DW] = cd[i];
      s_tkeep[i*KW +: KW] = ck[i];
      s_tuser[i*UW +: UW] = cu[i];
      s_tlast[i]          = (bi[i] == len[i] - 1);
    end
  endtask

  // Drive one cycle of stimulus and advance the model to the post-edge state.
  task automatic drive_and_predict();
    logic [N-1:0] elig;
    logic [N-1:0] others;
    bit           hs, out_hs, was_last;
    int           p;
    // requesters react to the previous cycle's accepted beats
    for (int i = 0; i < N; i++) begin
      if (prev_hs[i]) begin
        bi[i]++;
        if (bi[i] == len[i]) new_pkt(i);
        else new_beat(i);
        v[i] = (int'($urandom_range(99)) < vprob);
      end else if (!v[i]) begin
        v[i] = (int'($urandom_range(99)) < vprob);
      end
    end
    case (en_mode)
      0:       port_en = '1;
      1:       port_en = {3'b110, ($urandom_range(9) != 0) ? 1'b1 : 1'b0};
      default: port_en = N'($urandom);
    endcase
    m_tready = (int'($urandom_range(99)) < rprob);
    apply_inputs();

    hs       = mdl_busy && v[mdl_owner] && (mdl_occ < 2);
    out_hs   = (mdl_occ > 0) && m_tready;
    was_last = hs && (bi[mdl_owner] == len[mdl_owner] - 1);
    prev_hs  = '0;
    if (out_hs) begin
      void'(exp_q.pop_front());
      mdl_occ--;
    end
    if (hs) begin
      prev_hs[mdl_owner] = 1'b1;
      exp_q.push_back('{d: cd[mdl_owner], k: ck[mdl_owner], l: was_last, u: cu[mdl_owner]});
      mdl_occ++;
    end

    elig = v & port_en;
    if (!mdl_busy) begin
      p = first_after(elig, mdl_last);
      if (p >= 0) begin
        mdl_busy  = 1'b1;
        mdl_owner = p;
      end
    end else if (was_last) begin
      mdl_last = mdl_owner;
      others   = elig;
      others[mdl_owner] = 1'b0;
      p = first_after(others, mdl_owner);
      if (p < 0 && elig[mdl_owner]) p = mdl_owner;
      if (p >= 0) mdl_owner = p;
      else mdl_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (mdl_busy && mdl_occ < 2) exp_rdy[mdl_owner] = 1'b1;
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(mdl_occ > 0));
    chk("busy",     64'(busy),     64'(mdl_busy));
    if (mdl_busy) chk("grant_id", 64'(grant_id), 64'(mdl_owner));
    if (busy && grant_id == 2'd1) p1_grants++;
    if (mdl_occ > 0 && exp_q.size() > 0) begin
      chk("m_tdata", 64'(m_tdata), 64'(exp_q[0].d));
      chk("m_tkeep", 64'(m_tkeep), 64'(exp_q[0].k));
      chk("m_tlast", 64'(m_tlast), 64'(exp_q[0].l));
      chk("m_tuser", 64'(m_tuser), 64'(exp_q[0].u));
    end
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      drive_and_predict();
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < N; i++) pk[i] = 0;
    vprob = 100; rprob = 100; maxlen = 1; en_mode = 0;
    rst_n    = 1'b0;
    port_en  = '1;
    m_tready = 1'b1;
    model_reset();
    apply_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // all ports valid, single-beat packets, free-flowing output
    vprob = 100; rprob = 100; maxlen = 1; en_mode = 0;
    run(40);

    // multi-beat packets, random valid gaps and backpressure
    vprob = 70; rprob = 60; maxlen = 4; en_mode = 0;
    run(800);

    // port 1 disabled, port 0 enable flickering
    p1_grants = 0;
    vprob = 90; rprob = 70; maxlen = 4; en_mode = 1;
    run(400);
    chk("port1_never_granted", 64'(p1_grants), 64'd0);

    // sparse valids (owner stalls mid-packet), random enables, heavy backpressure
    vprob = 30; rprob = 50; maxlen = 4; en_mode = 2;
    run(800);

    // asynchronous reset in the middle of a multi-beat packet
    vprob = 100; rprob = 100; maxlen = 4; en_mode = 0;
    guard = 0;
    while (!(mdl_busy && bi[mdl_owner] >= 1 && len[mdl_owner] > 2) && guard < 200) begin
      run(1);
      guard++;
    end
    chk("mid_pkt_reached", 64'(guard < 200), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_in_reset("async_rst");
    model_reset();
    apply_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vprob = 80; rprob = 70; maxlen = 4; en_mode = 0;
    run(600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_eth_tx_pkt_rr_arb

`default_nettype wire
